// File: rtl/axis_demux_n.sv
// axis_demux_n
//   AXI4-Stream packet demultiplexer. Each packet arriving on the slave
//   stream is steered, whole, to one of NUM_PORTS master streams. The
//   destination is the user_id field of the first beat's tuser
//   (tuser[USER_ID_LSB +: USER_ID_WIDTH]). Packets whose user_id is not a
//   valid port number are consumed and discarded.
//
//   A single output register bank (valid/data/keep/user/last/port) sits
//   between the slave and all master ports. Slave ready is combinational
//   from the downstream ready of the port currently holding a beat, so
//   throughput is one beat per cycle with one cycle of latency.
//
// Ports
//   axis_aclk, axis_reset     clock, synchronous active-high reset
//   s_axis_*                  slave stream (tdata/tkeep/tuser/tvalid/tlast/tready)
//   m_axis_*                  master streams, port i in slice i of each bus
//
// Optional build macro: AXIS_DEMUX_STATS_EN
//   Adds stats_clear (in), drop_count (out, 32b) and pkt_count
//   (out, NUM_PORTS x 32b). The data path is identical either way.
//
// States
//   ST_IDLE | waiting for the first beat of a packet
//   ST_FWD  | mid-packet, beats go to port sel
//   ST_DROP | mid-packet, beats are consumed and discarded

module axis_demux_n #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS          = 4,
  parameter int USER_ID_LSB        = 32,
  parameter int USER_ID_WIDTH      = 8
) (
  input  logic                                          axis_aclk,
  input  logic                                          axis_reset,

  input  logic [C_AXIS_DATA_WIDTH-1:0]                  s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]                s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]                 s_axis_tuser,
  input  logic                                          s_axis_tvalid,
  input  logic                                          s_axis_tlast,
  output logic                                          s_axis_tready,

  output logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]      m_axis_tkeep,
  output logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]       m_axis_tuser,
  output logic [NUM_PORTS-1:0]                          m_axis_tvalid,
  output logic [NUM_PORTS-1:0]                          m_axis_tlast,
  input  logic [NUM_PORTS-1:0]                          m_axis_tready
`ifdef AXIS_DEMUX_STATS_EN
  ,
  input  logic                                          stats_clear,
  output logic [31:0]                                   drop_count,
  output logic [NUM_PORTS*32-1:0]                       pkt_count
`endif
);

  localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;
  localparam int PORT_W = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t                          state;
  logic [PORT_W-1:0]               sel;

  logic                            out_valid;
  logic [C_AXIS_DATA_WIDTH-1:0]    out_data;
  logic [KEEP_W-1:0]               out_keep;
  logic [C_AXIS_TUSER_WIDTH-1:0]   out_user;
  logic                            out_last;
  logic [PORT_W-1:0]               out_port;

  logic [USER_ID_WIDTH-1:0]        user_id;
  logic                            id_in_range;
  logic                            out_fire;
  logic                            out_free;
  logic                            accept;
  logic                            load;
  logic                            first_drop;
  logic [PORT_W-1:0]               load_port;

  assign user_id     = s_axis_tuser[USER_ID_LSB +: USER_ID_WIDTH];
  assign id_in_range = (32'(user_id) < 32'(NUM_PORTS));

  // The held beat leaves when its own port is ready; the register can take a
  // new beat in the same cycle, which is what gives back-to-back throughput.
  assign out_fire = out_valid & m_axis_tready[out_port];
  assign out_free = ~out_valid | m_axis_tready[out_port];

  // DROP never touches the output register, so it never needs to wait on it.
  assign s_axis_tready = ~axis_reset & ((state == ST_DROP) | out_free);
  assign accept        = s_axis_tvalid & s_axis_tready;

  // First beats route on their own user_id; later beats follow the latched sel.
  assign load_port  = (state == ST_IDLE) ? PORT_W'(user_id) : sel;
  assign load       = accept & (((state == ST_IDLE) & id_in_range) | (state == ST_FWD));
  assign first_drop = accept & (state == ST_IDLE) & ~id_in_range;

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state     <= ST_IDLE;
      sel       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_user  <= '0;
      out_last  <= 1'b0;
      out_port  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sel <= PORT_W'(user_id);
            // A single-beat packet is complete on acceptance.
            if (!s_axis_tlast) begin
              state <= id_in_range ? ST_FWD : ST_DROP;
            end
          end
        end
        ST_FWD: begin
          if (accept && s_axis_tlast) begin
            state <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (accept && s_axis_tlast) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (load) begin
        out_valid <= 1'b1;
        out_data  <= s_axis_tdata;
        out_keep  <= s_axis_tkeep;
        out_user  <= s_axis_tuser;
        out_last  <= s_axis_tlast;
        out_port  <= load_port;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Fan the single register out; every slice except the active one is zero.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = '0;
    m_axis_tlast  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (out_valid && (out_port == PORT_W'(i))) begin
        m_axis_tdata[i*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH]   = out_data;
        m_axis_tkeep[i*KEEP_W +: KEEP_W]                         = out_keep;
        m_axis_tuser[i*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH] = out_user;
        m_axis_tvalid[i]                                         = 1'b1;
        m_axis_tlast[i]                                          = out_last;
      end
    end
  end

`ifdef AXIS_DEMUX_STATS_EN
  // Clear wins over a same-cycle increment; counters wrap naturally.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset || stats_clear) begin
      drop_count <= '0;
      pkt_count  <= '0;
    end else begin
      if (first_drop) begin
        drop_count <= drop_count + 32'd1;
      end
      if (out_fire && out_last) begin
        pkt_count[32*out_port +: 32] <= pkt_count[32*out_port +: 32] + 32'd1;
      end
    end
  end
`else
  logic unused_first_drop;
  assign unused_first_drop = first_drop;
`endif

endmodule

// File: tb/tb_axis_demux_n.sv
module tb_axis_demux_n;

  localparam int DW     = 256;
  localparam int KW     = DW / 8;
  localparam int UW     = 128;
  localparam int NP     = 4;
  localparam int ID_LSB = 32;
  localparam int ID_W   = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [DW-1:0]      s_axis_tdata  = '0;
  logic [KW-1:0]      s_axis_tkeep  = '0;
  logic [UW-1:0]      s_axis_tuser  = '0;
  logic               s_axis_tvalid = 1'b0;
  logic               s_axis_tlast  = 1'b0;
  logic               s_axis_tready;
  logic [NP*DW-1:0]   m_axis_tdata;
  logic [NP*KW-1:0]   m_axis_tkeep;
  logic [NP*UW-1:0]   m_axis_tuser;
  logic [NP-1:0]      m_axis_tvalid;
  logic [NP-1:0]      m_axis_tlast;
  logic [NP-1:0]      m_axis_tready = '1;
`ifdef AXIS_DEMUX_STATS_EN
  logic               stats_clear = 1'b0;
  logic [31:0]        drop_count;
  logic [NP*32-1:0]   pkt_count;
`endif

  always #5 clk = ~clk;

  axis_demux_n #(
    .C_AXIS_DATA_WIDTH (DW),
    .C_AXIS_TUSER_WIDTH(UW),
    .NUM_PORTS         (NP),
    .USER_ID_LSB       (ID_LSB),
    .USER_ID_WIDTH     (ID_W)
  ) dut (
    .axis_aclk    (clk),
    .axis_reset   (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready)
`ifdef AXIS_DEMUX_STATS_EN
    ,
    .stats_clear  (stats_clear),
    .drop_count   (drop_count),
    .pkt_count    (pkt_count)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
    int            port;
    int            acc_cyc;
  } beat_t;

  beat_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int stall_cnt = 0;

  // Reference model: packet-level routing state
  bit in_pkt = 0;
  int cur_dest = -1;
  bit st_drop = 0;
  bit nx_drop = 0;
  int drops_exp = 0;
  int pkts_exp[NP];

  // downstream ready mode: 0 all ready, 1 random, 2 pattern on port 2
  int rmode = 0;
  bit rpat[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rmode == 1) begin
      m_axis_tready = NP'($urandom_range(0, (1 << NP) - 1));
    end else if (rmode == 2) begin
      m_axis_tready = '1;
      if (rpat.size() != 0) m_axis_tready[2] = rpat.pop_front();
    end else begin
      m_axis_tready = '1;
    end
  end

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [UW-1:0] make_user(input int uid);
    logic [UW-1:0] u;
    for (int k = 0; k < UW / 32; k++) u[32*k +: 32] = $urandom;
    u[ID_LSB +: ID_W] = ID_W'(uid);
    return u;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  task automatic next_cycle();
    @(negedge clk);
    st_drop = nx_drop;
  endtask

  // Called when a slave handshake will occur at the coming edge.
  task automatic model_accept();
    int uid;
    beat_t b;
    uid = int'(s_axis_tuser[ID_LSB +: ID_W]);
    if (!in_pkt) begin
      cur_dest = (uid < NP) ? uid : -1;
      if (cur_dest < 0) drops_exp++;
    end
    if (cur_dest >= 0) begin
      b.data = s_axis_tdata;
      b.keep = s_axis_tkeep;
      b.user = s_axis_tuser;
      b.last = s_axis_tlast;
      b.port = cur_dest;
      b.acc_cyc = cyc;
      exp_q.push_back(b);
    end
    in_pkt = !s_axis_tlast;
    nx_drop = in_pkt && (cur_dest < 0);
  endtask

  task automatic send_beat(input logic [UW-1:0] user, input logic last);
    bit acc;
    int tries;
    acc = 0;
    tries = 0;
    s_axis_tdata  = rand_data();
    s_axis_tkeep  = KW'($urandom);
    s_axis_tuser  = user;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    while (!acc) begin
      #2;
      if (s_axis_tready) begin
        acc = 1;
        model_accept();
      end
      next_cycle();
      if (!acc) begin
        tries++;
        if (tries > 100) begin
          n_chk++;
          n_fail++;
          $display("FAIL send_beat timeout: no s_axis_tready in 100 cycles");
          acc = 1;
        end
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int uid, input int len, input int gap);
    for (int b = 0; b < len; b++) begin
      // non-first beats carry an arbitrary user_id, which must be ignored
      send_beat(make_user(b == 0 ? uid : int'($urandom_range(0, 255))), (b == len - 1));
      if (gap > 0) begin
        s_axis_tvalid = 1'b0;
        repeat (gap) next_cycle();
      end
    end
  endtask

  task automatic clear_model();
    in_pkt = 0;
    cur_dest = -1;
    nx_drop = 0;
    st_drop = 0;
    drops_exp = 0;
    for (int i = 0; i < NP; i++) pkts_exp[i] = 0;
    exp_q.delete();
  endtask

  // Monitor: samples after inputs settle, before the next rising edge.
  initial begin
    bit prev_hold;
    int p;
    int q;
    prev_hold = 0;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        check("rst_s_tready", s_axis_tready, 0);
        prev_hold = 0;
      end else begin
        p = -1;
        for (int i = 0; i < NP; i++) if (m_axis_tvalid[i]) p = i;
        if (p >= 0) begin
          check("tvalid_onehot", $onehot(m_axis_tvalid), 1);
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat: port %0d tvalid=%b with nothing outstanding", p, m_axis_tvalid);
          end else begin
            check("out_port", p, exp_q[0].port);
            check("out_tdata", m_axis_tdata[p*DW +: DW], exp_q[0].data);
            check("out_tkeep", m_axis_tkeep[p*KW +: KW], exp_q[0].keep);
            check("out_tuser", m_axis_tuser[p*UW +: UW], exp_q[0].user);
            check("out_tlast", m_axis_tlast[p], exp_q[0].last);
            if (!prev_hold) check("latency", cyc, exp_q[0].acc_cyc + 1);
            q = (p + 1) % NP;
            check("idle_slice_zero", m_axis_tdata[q*DW +: DW], 0);
            if (m_axis_tready[p]) begin
              if (exp_q[0].last) pkts_exp[p]++;
              void'(exp_q.pop_front());
              prev_hold = 0;
            end else begin
              prev_hold = 1;
              stall_cnt++;
            end
          end
        end else begin
          check("no_tvalid", m_axis_tvalid, 0);
          prev_hold = 0;
        end
        check("s_tready", s_axis_tready, st_drop || !(p >= 0 && !m_axis_tready[p]));
      end
    end
  end

  initial begin
    int w;
    for (int i = 0; i < NP; i++) pkts_exp[i] = 0;
    rst = 1'b1;
    repeat (3) next_cycle();
    rst = 1'b0;
    clear_model();
    #2;
    check("reset_tvalid", m_axis_tvalid, 0);
    check("reset_tdata", m_axis_tdata, 0);
    check("post_reset_tready", s_axis_tready, 1);
    next_cycle();

    // 3-beat packets to every port, back to back, all ready
    rmode = 0;
    for (int u = 0; u < NP; u++) send_pkt(u, 3, 0);

    // out-of-range packet dropped, then a forwarded one
    send_pkt(7, 2, 0);
    send_pkt(1, 3, 0);
`ifdef AXIS_DEMUX_STATS_EN
    repeat (3) next_cycle();
    check("drop_count", drop_count, drops_exp);
`endif

    // port 2 backpressure during a 4-beat packet
    rmode = 2;
    rpat.push_back(1); rpat.push_back(0); rpat.push_back(0); rpat.push_back(1);
    send_pkt(2, 4, 0);
    repeat (4) next_cycle();
    rmode = 0;

    // single-beat packets alternating between ports 0 and 3
    for (int k = 0; k < 6; k++) send_pkt((k % 2 == 0) ? 0 : 3, 1, 0);

    // reset while beat 2 of a packet to port 1 is offered
    send_beat(make_user(1), 1'b0);
    rst = 1'b1;
    s_axis_tdata  = rand_data();
    s_axis_tuser  = make_user(1);
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    next_cycle();
    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    clear_model();
    #2;
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    check("mid_rst_tready", s_axis_tready, 1);
    next_cycle();
    send_pkt(0, 2, 0);

    // mid-packet beat carrying a different user_id stays on port 1
    send_beat(make_user(1), 1'b0);
    send_beat(make_user(3), 1'b0);
    send_beat(make_user(9), 1'b1);

    // randomized traffic with random backpressure
    rmode = 1;
    for (int n = 0; n < 150; n++) begin
      send_pkt(int'($urandom_range(0, 6)), int'($urandom_range(1, 4)), int'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) next_cycle();
    end

    rmode = 0;
    s_axis_tvalid = 1'b0;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      next_cycle();
      w++;
    end
    check("drain_empty", exp_q.size(), 0);
    check("stall_seen", (stall_cnt > 0), 1);
`ifdef AXIS_DEMUX_STATS_EN
    next_cycle();
    check("final_drop_count", drop_count, drops_exp);
    for (int i = 0; i < NP; i++) check("pkt_count", pkt_count[32*i +: 32], pkts_exp[i]);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
